// File: rtl/param_fifo_if.sv
// param_fifo_if: push/pop data and status bundle between a FIFO and its user.
interface param_fifo_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
);
  localparam int CW = $clog2(DEPTH) + 1;
  logic push;
  logic pop;
  logic clr_err;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] dout;
  logic full;
  logic empty;
  logic almost_full;
  logic almost_empty;
  logic [CW-1:0] count;
  logic overflow;
  logic underflow;
  modport slave (
    input  push, pop, clr_err, din,
    output dout, full, empty, almost_full, almost_empty, count, overflow, underflow
  );
  modport master (
    output push, pop, clr_err, din,
    input  dout, full, empty, almost_full, almost_empty, count, overflow, underflow
  );
endinterface

// File: rtl/param_fifo.sv
// param_fifo: circular-buffer FIFO with registered flags, sticky errors and optional FWFT read.
module param_fifo #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 16,
  parameter int AF_LVL = DEPTH - 2,
  parameter int AE_LVL = 2,
  parameter int FWFT   = 0
) (
  input logic clk,
  input logic rst,
  param_fifo_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] count_q, count_d;
  logic [WIDTH-1:0] dout_q;
  logic full_q, empty_q, af_q, ae_q, ovf_q, unf_q;
  logic pop_ok, push_ok, ovf_d, unf_d;
  always_comb begin
    pop_ok  = bus.pop & ~empty_q;
    push_ok = bus.push & (~full_q | pop_ok);
    count_d = count_q + CW'(push_ok) - CW'(pop_ok);
    ovf_d   = (bus.push & ~push_ok) | (ovf_q & ~bus.clr_err);
    unf_d   = (bus.pop & empty_q) | (unf_q & ~bus.clr_err);
  end
  always_ff @(posedge clk) begin
    if (!rst && push_ok) mem_q[wptr_q] <= bus.din;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      dout_q  <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      af_q    <= 1'b0;
      ae_q    <= 1'b1;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      if (push_ok) wptr_q <= wptr_q + AW'(1);
      if (pop_ok) begin
        rptr_q <= rptr_q + AW'(1);
        dout_q <= mem_q[rptr_q];
      end
      count_q <= count_d;
      full_q  <= count_d == CW'(DEPTH);
      empty_q <= count_d == '0;
      af_q    <= count_d >= CW'(AF_LVL);
      ae_q    <= count_d <= CW'(AE_LVL);
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end
  // FWFT shows the head word combinationally; zero while empty keeps reset dout at 0
  assign bus.dout         = (FWFT != 0) ? (empty_q ? '0 : mem_q[rptr_q]) : dout_q;
  assign bus.full         = full_q;
  assign bus.empty        = empty_q;
  assign bus.almost_full  = af_q;
  assign bus.almost_empty = ae_q;
  assign bus.count        = count_q;
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = unf_q;
endmodule

// File: tb/tb_param_fifo.sv
// tb_param_fifo: queue-model bench driving a registered-read and an FWFT FIFO side by side.
module tb_param_fifo;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic push = 1'b0, pop = 1'b0, clr_err = 1'b0;
  logic [7:0] din = '0;
  int errs = 0;
  int nchk = 0;
  logic [7:0] q[$];
  logic [7:0] exp_dout0 = '0;
  logic exp_ovf = 1'b0, exp_unf = 1'b0;

  always #5 clk = ~clk;

  param_fifo_if #(.WIDTH(8), .DEPTH(16)) b0 ();
  param_fifo_if #(.WIDTH(8), .DEPTH(16)) b1 ();
  assign b0.push = push;
  assign b0.pop = pop;
  assign b0.din = din;
  assign b0.clr_err = clr_err;
  assign b1.push = push;
  assign b1.pop = pop;
  assign b1.din = din;
  assign b1.clr_err = clr_err;

  param_fifo #(.WIDTH(8), .DEPTH(16), .FWFT(0)) dut0 (.clk(clk), .rst(rst), .bus(b0));
  param_fifo #(.WIDTH(8), .DEPTH(16), .FWFT(1)) dut1 (.clk(clk), .rst(rst), .bus(b1));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic compare();
    int n = q.size();
    chk("count0", 32'(b0.count), 32'(n));
    chk("count1", 32'(b1.count), 32'(n));
    chk("empty", {b1.empty, b0.empty}, {2{n == 0}});
    chk("full", {b1.full, b0.full}, {2{n == 16}});
    chk("almost_full", {b1.almost_full, b0.almost_full}, {2{n >= 14}});
    chk("almost_empty", {b1.almost_empty, b0.almost_empty}, {2{n <= 2}});
    chk("overflow", {b1.overflow, b0.overflow}, {2{exp_ovf}});
    chk("underflow", {b1.underflow, b0.underflow}, {2{exp_unf}});
    chk("dout0", 32'(b0.dout), 32'(exp_dout0));
    if (n > 0) chk("dout1", 32'(b1.dout), 32'(q[0]));
  endtask

  task automatic step(input logic pu, input logic po, input logic [7:0] d, input logic c, input logic r);
    logic pop_ok, push_ok, new_ovf, new_unf;
    push = pu; pop = po; din = d; clr_err = c; rst = r;
    @(posedge clk);
    if (r) begin
      q.delete();
      exp_dout0 = '0;
      exp_ovf = 1'b0;
      exp_unf = 1'b0;
    end else begin
      pop_ok  = po && q.size() > 0;
      push_ok = pu && (q.size() < 16 || pop_ok);
      new_ovf = pu && !push_ok;
      new_unf = po && q.size() == 0;
      if (pop_ok) exp_dout0 = q.pop_front();
      if (push_ok) q.push_back(d);
      exp_ovf = new_ovf | (exp_ovf & ~c);
      exp_unf = new_unf | (exp_unf & ~c);
    end
    @(negedge clk);
    compare();
  endtask

  initial begin
    step(0, 0, 8'h00, 0, 1);
    step(1, 1, 8'h33, 1, 1);
    chk("lit_reset_count", 32'(b0.count), 0);
    chk("lit_reset_flags", {b0.empty, b0.almost_empty, b0.full, b0.almost_full}, 4'b1100);
    chk("lit_reset_dout", 32'(b0.dout), 0);
    for (int i = 1; i <= 16; i++) begin
      step(1, 0, 8'(i), 0, 0);
      if (i == 3) chk("lit_ae_off", 32'(b0.almost_empty), 0);
      if (i == 13) chk("lit_af_13", 32'(b0.almost_full), 0);
      if (i == 14) chk("lit_af_14", 32'(b0.almost_full), 1);
    end
    chk("lit_full", {b0.full, 5'(b0.count)}, {1'b1, 5'd16});
    step(1, 0, 8'h99, 0, 0);
    chk("lit_overflow", {b0.overflow, 5'(b0.count)}, {1'b1, 5'd16});
    step(0, 0, 8'h00, 1, 0);
    for (int i = 1; i <= 16; i++) begin
      step(0, 1, 8'h00, 0, 0);
      chk("lit_drain", 32'(b0.dout), 32'(i));
    end
    chk("lit_drained_empty", 32'(b0.empty), 1);
    step(0, 1, 8'h00, 0, 0);
    chk("lit_underflow", {b0.underflow, b0.dout}, {1'b1, 8'h10});
    step(0, 0, 8'h00, 1, 0);
    step(1, 1, 8'h5A, 0, 0);
    chk("lit_empty_pushpop", {b0.underflow, 5'(b0.count)}, {1'b1, 5'd1});
    chk("lit_fwft_dout", 32'(b1.dout), 32'h5A);
    step(0, 1, 8'h00, 1, 0);
    chk("lit_fwft_empty", 32'(b1.empty), 1);
    step(1, 0, 8'hA5, 0, 0);
    chk("lit_fwft_a5", {b1.empty, b1.dout}, {1'b0, 8'hA5});
    step(0, 1, 8'h00, 0, 0);
    for (int i = 0; i < 10; i++) step(1, 0, 8'(8'h20 + i), 0, 0);
    for (int i = 0; i < 10; i++) step(0, 1, 8'h00, 0, 0);
    for (int i = 0; i < 16; i++) step(1, 0, 8'(8'h40 + i), 0, 0);
    step(1, 1, 8'h77, 0, 0);
    chk("lit_full_pushpop", {b0.full, 5'(b0.count), b0.dout}, {1'b1, 5'd16, 8'h40});
    for (int i = 0; i < 16; i++) step(0, 1, 8'h00, 0, 0);
    chk("lit_wrap_last", {b0.empty, b0.dout, b0.overflow, b0.underflow}, {1'b1, 8'h77, 2'b00});
    for (int i = 0; i < 7; i++) step(1, 0, 8'(8'h60 + i), 0, 0);
    step(0, 1, 8'h00, 0, 0);
    step(1, 0, 8'h67, 0, 0);
    step(0, 1, 8'h00, 1, 0);
    step(1, 1, 8'hEE, 0, 1);
    chk("lit_midburst_rst", {5'(b0.count), b0.empty, b0.overflow, b0.underflow, b0.dout},
        {5'd0, 1'b1, 2'b00, 8'h00});
    for (int i = 0; i < 3000; i++) begin
      int ph = (i / 100) % 3;
      int pp = (ph == 0) ? 75 : (ph == 1) ? 25 : 50;
      step($urandom_range(0, 99) < pp, $urandom_range(0, 99) < (100 - pp),
           8'($urandom), $urandom_range(0, 19) == 0, $urandom_range(0, 299) == 0);
    end
    $display("Result: errors=%0d of %0d checks", errs, nchk);
    $finish;
  end
endmodule
